axis_uart_tx_arb: RTL and testbench
===================================

# axis_uart_tx_arb

Round-robin AXI-Stream arbiter that shares a single UART transmit stream between N_REQ requesters. Sits in front of the TX slave port of axis_uart_top, so several producers can send to one serial line. Each grant holds for a whole packet, ending on tlast, and each granted beat passes through to the master port without a register stage. A beat watchdog forces release if a requester never asserts tlast.

## Interface
- N_REQ, 4: number of requesting streams, 1..16.
- DATA_WIDTH, 8: tdata width, matching the UART data width.
- MAX_BEATS, 256: maximum beats per grant before forced release, ≥1.
- clk_i  in  1  system clock; all logic sits on its rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- s_axis_tdata_i  in  N_REQ×DATA_WIDTH  requester data, packed with requester k at slice k.
- s_axis_tvalid_i  in  N_REQ  requester valid.
- s_axis_tlast_i  in  N_REQ  requester end of packet.
- s_axis_tready_o  out  N_REQ  requester ready.
- m_axis_tdata_o  out  DATA_WIDTH  data to the UART TX.
- m_axis_tvalid_o  out  1  valid to the UART TX.
- m_axis_tlast_o  out  1  last to the UART TX.
- m_axis_tready_i  in  1  ready from the UART TX.
- grant_o  out  $clog2(N_REQ), minimum 1  index of the current owner.
- busy_o  out  1  high while a grant is held.
- timeout_o  out  1  one-cycle pulse when the watchdog forces a release.

## Operation
- FSM states:
  - IDLE: no owner.
  - BUSY: owner is grant_o.
- Round-robin choice: the search starts at index (last_grant+1) mod N_REQ and picks the first requester with tvalid high.
- IDLE with any tvalid: register the chosen index into grant_o and move to BUSY. No data moves in IDLE.
- BUSY, datapath:
  - m_axis_tdata/tvalid/tlast come from requester grant_o.
  - s_axis_tready_o[grant_o] = m_axis_tready_i.
  - All other s_axis_tready_o bits are 0.
- A handshake is m_axis_tvalid_o & m_axis_tready_i.
- Handshake with tlast: go to IDLE, set last_grant ← grant_o, clear the beat counter.
- Beat counter: counts handshakes within the current grant; width is $clog2(MAX_BEATS+1).
- Forced release: on the handshake that brings the count to MAX_BEATS without tlast, go to IDLE, set last_grant ← grant_o, pulse timeout_o for one cycle. The requester keeps the rest of its packet and re-arbitrates like any other requester.
- tlast and the MAX_BEATS count on the same beat: this is a normal release and timeout_o stays 0.
- The owner dropping tvalid mid-packet does not release the grant; the arbiter waits.
- Requesters that are not granted see tready=0. Their tdata and tlast are ignored.
- N_REQ=1: grant_o stays 0 and the packet/IDLE alternation is unchanged.

## Timing
- Reset values:
  - State IDLE, last_grant = N_REQ-1, so requester 0 wins first.
  - grant_o = 0, busy_o = 0, timeout_o = 0.
  - All s_axis_tready_o = 0, m_axis_tvalid_o = 0, m_axis_tlast_o = 0, m_axis_tdata_o = 0.
- Reset asserted mid-packet: abort the grant in the same edge; no beat is accepted in that cycle.
- Grant latency: tvalid seen in IDLE at cycle t → busy_o and the forwarded tvalid appear at cycle t+1.
- Data path: combinational from the owner to m_axis, with no added latency.
- Each release costs exactly one IDLE cycle between grants, with or without a competing requester.
- While busy, the combinational path m_axis_tready_i → s_axis_tready_o is permitted. The UART side registers its own ready.
- AXI-Stream rules hold on both sides: the arbiter never drops valid without a handshake on the master port while BUSY.

## Configuration
- AXIS_ARB_PKT_LOCK_EN defined: the grant is held until tlast or the watchdog fires, as described above.
- AXIS_ARB_PKT_LOCK_EN undefined:
  - Every handshake releases the grant, giving beat-level round-robin.
  - tlast passes through unchanged but is not used for arbitration.
  - The watchdog logic and timeout_o tie off: timeout_o is held at 0.

## Structure
- Package axis_arb_pkg holds:
  - the state enum {IDLE, BUSY};
  - the function that sizes the grant index width (clog2 with minimum 1);
  - the beat-counter width function.
- Sub-module axis_rr_picker: combinational round-robin first-one search. Inputs are the request vector and last_grant; outputs are the index and a valid flag.

## Test plan
- Reset, then requesters 0 and 2 each hold a 3-beat packet, m_axis_tready_i=1:
  - master port shows req0 beats, one idle cycle, then req2 beats;
  - grant_o sequence 0 then 2.
- All four requesters hold 1-beat packets continuously:
  - grants rotate 0,1,2,3,0;
  - each grant is separated by one IDLE cycle.
- m_axis_tready_i toggles every other cycle during a 4-beat req1 packet:
  - tdata stays stable while stalled;
  - exactly 4 handshakes, release after the tlast beat.
- MAX_BEATS=4, req3 sends 6 beats and never asserts tlast:
  - release after the 4th handshake with timeout_o high for one cycle;
  - req3 is re-granted for the remaining beats after the other requesters.
- rst_i asserted on the 2nd beat of a 3-beat packet:
  - next cycle all outputs are at reset values;
  - requester 0 is granted first afterwards.
- AXIS_ARB_PKT_LOCK_EN undefined, req0 and req1 each send 2-beat packets:
  - beats interleave on the master port as req0, req1, req0, req1;
  - timeout_o stays 0.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and sizing helpers for the AXI-Stream UART TX arbiter.
// Build option: AXIS_ARB_PKT_LOCK_EN selects packet-locked grants with a
// beat watchdog; without it the arbiter rotates on every beat.
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Grant index width: clog2 of the requester count, never less than 1 bit.
  function automatic int idx_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

  // Beat counter width: must be able to hold the value max_beats itself.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/axis_rr_picker.sv
// Combinational round-robin first-one search. The search starts one past
// last_i and wraps, so the most recent owner has the lowest priority.
module axis_rr_picker
  import axis_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int   cand;
  logic found;

  // Walk the requesters in rotated order and keep the first active one.
  always_comb begin
    cand  = 0;
    found = 1'b0;
    idx_o = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = (int'(last_i) + i) % N_REQ;
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
    vld_o = found;
  end

endmodule

// File: rtl/axis_uart_tx_arb.sv
// Round-robin AXI-Stream arbiter in front of a single UART TX slave port.
// The owner's beats pass straight through to the master port; one IDLE
// cycle separates every pair of grants.
// Build option: AXIS_ARB_PKT_LOCK_EN holds each grant until tlast or until
// MAX_BEATS handshakes (watchdog, pulses timeout_o). Without it every
// handshake releases the grant and timeout_o is tied low.
// Valid/ready: a beat moves only on a cycle where m_axis_tvalid_o and
// m_axis_tready_i are both high; the owner's tready mirrors m_axis_tready_i
// and every other requester sees tready low.
module axis_uart_tx_arb
  import axis_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BEATS  = 256,
  localparam int IDX_W      = idx_width(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic [N_REQ-1:0]            s_axis_tvalid_i,
  input  logic [N_REQ-1:0]            s_axis_tlast_i,
  output logic [N_REQ-1:0]            s_axis_tready_o,
  output logic [DATA_WIDTH-1:0]       m_axis_tdata_o,
  output logic                        m_axis_tvalid_o,
  output logic                        m_axis_tlast_o,
  input  logic                        m_axis_tready_i,
  output logic [IDX_W-1:0]            grant_o,
  output logic                        busy_o,
  output logic                        timeout_o
);

  localparam int CNT_W = cnt_width(MAX_BEATS);

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_vld;
  logic                  active;
  logic                  hs;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  own_valid;
  logic                  own_last;

`ifdef AXIS_ARB_PKT_LOCK_EN
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             timeout_q, timeout_d;
  assign timeout_o = timeout_q;
`else
  // Watchdog is absent in beat-level mode; MAX_BEATS is only sized here.
  logic [CNT_W-1:0] unused_max_beats;
  assign unused_max_beats = CNT_W'(MAX_BEATS);
  assign timeout_o        = 1'b0;
`endif

  axis_rr_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i  (s_axis_tvalid_i),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  assign grant_o = grant_q;
  assign busy_o  = (state_q == BUSY);

  // Pass-through mux from the owner; reset blocks any beat in its own cycle.
  always_comb begin
    active          = (state_q == BUSY) && !rst_i;
    own_data        = s_axis_tdata_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
    own_valid       = s_axis_tvalid_i[grant_q];
    own_last        = s_axis_tlast_i[grant_q];
    m_axis_tvalid_o = active & own_valid;
    m_axis_tlast_o  = active & own_last;
    m_axis_tdata_o  = active ? own_data : '0;
    s_axis_tready_o = '0;
    if (active) begin
      s_axis_tready_o[grant_q] = m_axis_tready_i;
    end
    hs = m_axis_tvalid_o & m_axis_tready_i;
  end

  // Grant/release decisions: acquire in IDLE, release on the deciding beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef AXIS_ARB_PKT_LOCK_EN
    beat_cnt_d = beat_cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
`ifdef AXIS_ARB_PKT_LOCK_EN
          if (m_axis_tlast_o) begin
            state_d    = IDLE;
            last_d     = grant_q;
            beat_cnt_d = '0;
          end else if (beat_cnt_q == LAST_CNT) begin
            state_d    = IDLE;
            last_d     = grant_q;
            beat_cnt_d = '0;
            timeout_d  = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
`else
          state_d = IDLE;
          last_d  = grant_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset leaves requester 0 as the first winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
`ifdef AXIS_ARB_PKT_LOCK_EN
      beat_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef AXIS_ARB_PKT_LOCK_EN
      beat_cnt_q <= beat_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Bench for axis_uart_tx_arb (N_REQ=4, DATA_WIDTH=8, MAX_BEATS=4).
// Per-cycle vector table for arbitration basics, then scoreboarded
// multi-cycle sequences whose expected beats depend on AXIS_ARB_PKT_LOCK_EN.
module tb_axis_uart_tx_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]  s_tvalid;
  logic [N-1:0]  s_tlast;
  logic [N-1:0]  s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [1:0]    grant;
  logic          busy;
  logic          timeout;

  axis_uart_tx_arb #(
    .N_REQ      (N),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MB)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .s_axis_tdata_i  (s_tdata),
    .s_axis_tvalid_i (s_tvalid),
    .s_axis_tlast_i  (s_tlast),
    .s_axis_tready_o (s_tready),
    .m_axis_tdata_o  (m_tdata),
    .m_axis_tvalid_o (m_tvalid),
    .m_axis_tlast_o  (m_tlast),
    .m_axis_tready_i (m_tready),
    .grant_o         (grant),
    .busy_o          (busy),
    .timeout_o       (timeout)
  );

  // Scoreboard state: expected beat = {cycle, grant, tlast, tdata}
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_to_cyc = -1;
  logic [18:0] exp_q[$];
  logic [8:0]  src_mem[N][16];
  int          src_rd[N];
  int          src_wr[N];
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        chk_rst;

  typedef struct {
    logic       rst;
    logic [3:0] tv;
    logic       tr;
    logic       busy;
    logic [1:0] gnt;
    logic       mv;
    logic [3:0] sr;
  } vec_t;
  vec_t tbl[21];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] bd(input int k, input int i);
    return 8'(k * 16 + i);
  endfunction

  task automatic push_src(input int k, input logic [7:0] d, input logic l);
    src_mem[k][src_wr[k]] = {l, d};
    src_wr[k]++;
  endtask

  task automatic push_exp(input int c, input int g, input logic l, input logic [7:0] d);
    exp_q.push_back({8'(c), 2'(g), l, d});
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    s_tvalid   = '0;
    s_tlast    = '0;
    s_tdata    = '0;
    m_tready   = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    chk_rst    = 1'b0;
    exp_to_cyc = -1;
    for (int k = 0; k < N; k++) begin
      src_rd[k] = 0;
      src_wr[k] = 0;
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_i = 1'b0;
    cyc   = 0;
  endtask

  task automatic check_reset_vals();
    cmp("rv_busy",    32'(busy),     32'(0));
    cmp("rv_grant",   32'(grant),    32'(0));
    cmp("rv_mvalid",  32'(m_tvalid), 32'(0));
    cmp("rv_mlast",   32'(m_tlast),  32'(0));
    cmp("rv_mdata",   32'(m_tdata),  32'(0));
    cmp("rv_sready",  32'(s_tready), 32'(0));
    cmp("rv_timeout", 32'(timeout),  32'(0));
  endtask

  task automatic end_seq(input string name);
    cmp(name, 32'(exp_q.size()), 32'(0));
  endtask

  // Driver + monitor for one clock: present source heads, check, advance.
  task automatic step();
    logic [18:0] got;
    logic [18:0] want;
    for (int k = 0; k < N; k++) begin
      if (src_rd[k] != src_wr[k]) begin
        s_tvalid[k]         = 1'b1;
        s_tdata[k*DW +: DW] = src_mem[k][src_rd[k]][7:0];
        s_tlast[k]          = src_mem[k][src_rd[k]][8];
      end else begin
        s_tvalid[k]         = 1'b0;
        s_tdata[k*DW +: DW] = 8'($urandom_range(0, 255));
        s_tlast[k]          = 1'($urandom_range(0, 1));
      end
    end
    #1;
    cmp("timeout", 32'(timeout), 32'(cyc == exp_to_cyc));
    if (rst_i) begin
      cmp("rst_mvalid", 32'(m_tvalid), 32'(0));
      cmp("rst_sready", 32'(s_tready), 32'(0));
    end
    if (chk_rst) check_reset_vals();
    if (prev_stall && !rst_i) begin
      cmp("stall_hold", 32'({m_tvalid, m_tdata}), 32'({1'b1, prev_data}));
    end
    if (m_tvalid && m_tready) begin
      got = {8'(cyc), grant, m_tlast, m_tdata};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL beat @cycle %0d: got %0h expected none", cyc, got);
      end else begin
        want = exp_q.pop_front();
        cmp("beat", 32'(got), 32'(want));
      end
    end
    prev_stall = m_tvalid && !m_tready && !rst_i;
    prev_data  = m_tdata;
    for (int k = 0; k < N; k++) begin
      if (s_tvalid[k] && s_tready[k]) src_rd[k]++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst_i    = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    @(negedge clk);
    do_reset();

    // ---- Table: 1-beat packets, rotation, stall, owner dropping valid ----
    //            rst   tv      tr    busy  gnt  mv    sr
    tbl[0]  = '{1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[7]  = '{1'b0, 4'b1111, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0000};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};
    tbl[10] = '{1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
    tbl[11] = '{1'b0, 4'b1010, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
    tbl[12] = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
    tbl[13] = '{1'b0, 4'b1010, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
    tbl[14] = '{1'b0, 4'b1010, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
    tbl[15] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
    tbl[16] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
    tbl[17] = '{1'b0, 4'b0001, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
    tbl[18] = '{1'b0, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4'b0001};
    tbl[19] = '{1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
    tbl[20] = '{1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
    for (int i = 0; i < 21; i++) begin
      cyc      = i;
      rst_i    = tbl[i].rst;
      s_tvalid = tbl[i].tv;
      s_tlast  = 4'hF;
      s_tdata  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      m_tready = tbl[i].tr;
      #1;
      cmp("tbl_busy",    32'(busy),     32'(tbl[i].busy));
      cmp("tbl_grant",   32'(grant),    32'(tbl[i].gnt));
      cmp("tbl_mvalid",  32'(m_tvalid), 32'(tbl[i].mv));
      cmp("tbl_sready",  32'(s_tready), 32'(tbl[i].sr));
      cmp("tbl_timeout", 32'(timeout),  32'(0));
      if (tbl[i].busy) begin
        cmp("tbl_mdata", 32'(m_tdata), 32'(8'hA0 + 8'(tbl[i].gnt)));
        cmp("tbl_mlast", 32'(m_tlast), 32'(1));
      end
      @(posedge clk);
      @(negedge clk);
    end

    // ---- Seq A: req0 and req2 each a 3-beat packet ----
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push_src(0, bd(0, i), i == 2);
      push_src(2, bd(2, i), i == 2);
    end
`ifdef AXIS_ARB_PKT_LOCK_EN
    push_exp(1, 0, 1'b0, bd(0, 0)); push_exp(2, 0, 1'b0, bd(0, 1)); push_exp(3, 0, 1'b1, bd(0, 2));
    push_exp(5, 2, 1'b0, bd(2, 0)); push_exp(6, 2, 1'b0, bd(2, 1)); push_exp(7, 2, 1'b1, bd(2, 2));
`else
    push_exp(1, 0, 1'b0, bd(0, 0)); push_exp(3, 2, 1'b0, bd(2, 0)); push_exp(5, 0, 1'b0, bd(0, 1));
    push_exp(7, 2, 1'b0, bd(2, 1)); push_exp(9, 0, 1'b1, bd(0, 2)); push_exp(11, 2, 1'b1, bd(2, 2));
`endif
    repeat (13) step();
    end_seq("seqA_left");

    // ---- Seq B: 4-beat req1 packet, master ready on even cycles only ----
    do_reset();
    for (int i = 0; i < 4; i++) push_src(1, bd(1, i), i == 3);
    push_exp(2, 1, 1'b0, bd(1, 0)); push_exp(4, 1, 1'b0, bd(1, 1));
    push_exp(6, 1, 1'b0, bd(1, 2)); push_exp(8, 1, 1'b1, bd(1, 3));
    repeat (10) begin
      m_tready = (cyc % 2 == 0);
      step();
    end
    m_tready = 1'b1;
    end_seq("seqB_left");

    // ---- Seq C: req3 sends 6 beats without tlast; req0/req1 join later ----
    do_reset();
    for (int i = 0; i < 6; i++) push_src(3, bd(3, i), 1'b0);
`ifdef AXIS_ARB_PKT_LOCK_EN
    exp_to_cyc = 5;
    for (int i = 0; i < 4; i++) push_exp(1 + i, 3, 1'b0, bd(3, i));
    push_exp(6, 0, 1'b1, bd(0, 0)); push_exp(8, 1, 1'b1, bd(1, 0));
    push_exp(10, 3, 1'b0, bd(3, 4)); push_exp(11, 3, 1'b0, bd(3, 5));
`else
    exp_to_cyc = -1;
    push_exp(1, 3, 1'b0, bd(3, 0)); push_exp(3, 0, 1'b1, bd(0, 0)); push_exp(5, 1, 1'b1, bd(1, 0));
    for (int i = 1; i < 6; i++) push_exp(5 + 2 * i, 3, 1'b0, bd(3, i));
`endif
    repeat (16) begin
      if (cyc == 2) begin
        push_src(0, bd(0, 0), 1'b1);
        push_src(1, bd(1, 0), 1'b1);
      end
      step();
    end
    exp_to_cyc = -1;
    end_seq("seqC_left");

    // ---- Seq D: reset on the 2nd beat of a req1 packet ----
    do_reset();
    for (int i = 0; i < 3; i++) push_src(1, bd(1, i), i == 2);
    push_exp(1, 1, 1'b0, bd(1, 0)); push_exp(4, 0, 1'b1, bd(0, 0));
`ifdef AXIS_ARB_PKT_LOCK_EN
    push_exp(6, 1, 1'b0, bd(1, 1)); push_exp(7, 1, 1'b1, bd(1, 2));
`else
    push_exp(6, 1, 1'b0, bd(1, 1)); push_exp(8, 1, 1'b1, bd(1, 2));
`endif
    repeat (10) begin
      if (cyc == 2) rst_i = 1'b1;
      if (cyc == 3) begin
        rst_i   = 1'b0;
        chk_rst = 1'b1;
        push_src(0, bd(0, 0), 1'b1);
      end
      step();
      chk_rst = 1'b0;
    end
    end_seq("seqD_left");

    // ---- Seq E: req0 and req1 each a 2-beat packet ----
    do_reset();
    for (int i = 0; i < 2; i++) begin
      push_src(0, bd(0, i), i == 1);
      push_src(1, bd(1, i), i == 1);
    end
`ifdef AXIS_ARB_PKT_LOCK_EN
    push_exp(1, 0, 1'b0, bd(0, 0)); push_exp(2, 0, 1'b1, bd(0, 1));
    push_exp(4, 1, 1'b0, bd(1, 0)); push_exp(5, 1, 1'b1, bd(1, 1));
`else
    push_exp(1, 0, 1'b0, bd(0, 0)); push_exp(3, 1, 1'b0, bd(1, 0));
    push_exp(5, 0, 1'b1, bd(0, 1)); push_exp(7, 1, 1'b1, bd(1, 1));
`endif
    repeat (9) step();
    end_seq("seqE_left");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
